param_universal_shift_register: RTL

- Parametrised universal shift register. Successor to the fixed 4-bit PIPO/SISO/SIPO/PISO registers.
- One block provides hold, parallel load, left and right shift, and left and right rotate at any width.
- Adds an autonomous full-duplex frame engine: it loads a word, shifts it out LSB-first for exactly WIDTH cycles while capturing serial input, then pulses done.
- Sits between parallel datapath logic and serial links (SPI-like or daisy-chain).

---
 rtl/param_universal_shift_register.sv | 138 +++++++++++++
 1 files changed

// File: rtl/param_universal_shift_register.sv
// ---------------------------------------------------------------------------
// param_universal_shift_register
//
// Purpose:
//   Universal shift register of any width. It holds, loads in parallel, and
//   shifts or rotates left or right. It also contains a full-duplex frame
//   engine. The engine loads a word, shifts it out LSB-first for exactly
//   WIDTH cycles while capturing serial_in_r, and then pulses done for one
//   cycle. The block sits between parallel datapath logic and a serial link.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   clr          synchronous clear (q <= RST_VAL, engine back to IDLE)
//   mode[2:0]    manual operation, honoured only while IDLE and start=0
//   parallel_in  load / frame word
//   serial_in_r  bit entering the MSB on right shift and frame shift
//   serial_in_l  bit entering the LSB on left shift
//   start        begin a frame, sampled only in IDLE
//   parallel_out current register contents
//   serial_out_r q[0]
//   serial_out_l q[WIDTH-1]
//   busy         frame engine is shifting
//   done         one-cycle pulse after the last frame shift
//   bit_cnt      shifts completed in the current frame
// ---------------------------------------------------------------------------
module param_universal_shift_register #(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = $clog2(WIDTH + 1),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic             start,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_SHR   = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_ROR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_LOAD  = 3'b101;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The priority order is clr, then the running frame, then start, then mode.
  // DONE keeps q steady so the received word can be read while done is high.
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (clr) begin
      q_d     = RST_VAL;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SHIFT: begin
          q_d = {serial_in_r, q_q[WIDTH-1:1]};
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            cnt_d   = FULL_CNT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end

        default: begin
          if (start) begin
            q_d     = parallel_in;
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            case (mode)
              MODE_SHR:  q_d = {serial_in_r, q_q[WIDTH-1:1]};
              MODE_SHL:  q_d = {q_q[WIDTH-2:0], serial_in_l};
              MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
              MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              MODE_LOAD: q_d = parallel_in;
              MODE_HOLD: q_d = q_q;
              default:   q_d = q_q;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q     <= RST_VAL;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // busy and done decode straight from the state register. This keeps every
  // output free of any combinational path from the inputs.
  assign parallel_out = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];
  assign busy         = (state_q == SHIFT);
  assign done         = (state_q == DONE);
  assign bit_cnt      = cnt_q;

endmodule
